// File: rtl/axi_llc_pkg.sv
// Shared helpers for the LLC way router: unit-tag sizing and one-hot way index checks.
package axi_llc_pkg;

    // Upper bound on set associativity; selections are zero-extended to this width.
    localparam int unsigned MaxNumWays = 64;

    typedef logic [MaxNumWays-1:0] way_ind_t;

    function automatic int unsigned unit_tag_w(input int unsigned num_units);
        return (num_units > 1) ? $clog2(num_units) : 1;
    endfunction

    function automatic logic way_ind_legal(input way_ind_t ind);
        return $onehot(ind);
    endfunction

endpackage

// File: rtl/axi_llc_order_fifo.sv
// Non-fall-through ordering FIFO of one-hot way indices; push and pop may coincide even when full.
module axi_llc_order_fifo #(
    parameter int unsigned Depth = 5,
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_llc_way_router.sv
// Routes LLC unit requests to one-hot selected ways (round-robin with lock-in per way)
// and returns way responses to read-capable units in each unit's issue order.
module axi_llc_way_router
    import axi_llc_pkg::*;
#(
    parameter int unsigned          NumUnits   = 4,
    parameter int unsigned          NumWays    = 4,
    parameter logic [NumUnits-1:0]  ReadMask   = 4'b1001,
    parameter int unsigned          OrderDepth = 5,
    parameter type                  req_t      = logic,
    parameter type                  rsp_t      = logic
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  req_t [NumUnits-1:0]                           unit_req_i,
    input  logic [NumUnits-1:0][NumWays-1:0]              unit_sel_i,
    input  logic [NumUnits-1:0]                           unit_req_valid_i,
    output logic [NumUnits-1:0]                           unit_req_ready_o,
    output req_t [NumWays-1:0]                            way_req_o,
    output logic [NumWays-1:0][unit_tag_w(NumUnits)-1:0]  way_req_unit_o,
    output logic [NumWays-1:0]                            way_req_valid_o,
    input  logic [NumWays-1:0]                            way_req_ready_i,
    input  rsp_t [NumWays-1:0]                            way_rsp_i,
    input  logic [NumWays-1:0][unit_tag_w(NumUnits)-1:0]  way_rsp_unit_i,
    input  logic [NumWays-1:0]                            way_rsp_valid_i,
    output logic [NumWays-1:0]                            way_rsp_ready_o,
    output rsp_t [NumUnits-1:0]                           unit_rsp_o,
    output logic [NumUnits-1:0]                           unit_rsp_valid_o,
    input  logic [NumUnits-1:0]                           unit_rsp_ready_i,
    output logic                                          busy_o,
    output logic                                          err_sel_o
);

    localparam int unsigned UnitW = unit_tag_w(NumUnits);

    logic [NumUnits-1:0]              sel_legal, sel_illegal, elig, push_leg, rsp_pop;
    logic [NumUnits-1:0]              fifo_full, fifo_empty;
    logic [NumUnits-1:0][NumWays-1:0] fifo_head, rsp_match;
    logic [NumWays-1:0][UnitW-1:0]    gnt;
    logic [NumWays-1:0]               way_hs, rsp_proto_err;
    logic                             err_q, err_d;

    // A full ordering FIFO hides the unit from arbitration so a way never sees an unacceptable request.
    always_comb begin
        sel_legal   = '0;
        sel_illegal = '0;
        elig        = '0;
        for (int unsigned u = 0; u < NumUnits; u++) begin
            sel_legal[u]   = way_ind_legal(way_ind_t'(unit_sel_i[u]));
            sel_illegal[u] = unit_req_valid_i[u] & ~sel_legal[u];
            elig[u]        = unit_req_valid_i[u] & sel_legal[u] & ~(ReadMask[u] & fifo_full[u]);
        end
    end

    for (genvar w = 0; w < NumWays; w++) begin : g_way
        logic [NumUnits-1:0] cand;
        logic [UnitW-1:0]    ptr_q, ptr_d, lock_unit_q, lock_unit_d, rr_pick;
        logic                lock_q, lock_d, rr_found;
        int unsigned         idx;

        always_comb begin
            cand = '0;
            for (int unsigned u = 0; u < NumUnits; u++) begin
                cand[u] = elig[u] & unit_sel_i[u][w];
            end
        end

        always_comb begin
            rr_found = 1'b0;
            rr_pick  = '0;
            idx      = 0;
            for (int unsigned i = 0; i < NumUnits; i++) begin
                idx = (32'(ptr_q) + i) % NumUnits;
                if (!rr_found && cand[idx]) begin
                    rr_found = 1'b1;
                    rr_pick  = UnitW'(idx);
                end
            end
        end

        assign gnt[w]             = lock_q ? lock_unit_q : rr_pick;
        assign way_req_valid_o[w] = ~rst_i & (lock_q ? cand[lock_unit_q] : rr_found);
        assign way_hs[w]          = way_req_valid_o[w] & way_req_ready_i[w];
        assign way_req_o[w]       = unit_req_i[gnt[w]];
        assign way_req_unit_o[w]  = gnt[w];

        always_comb begin
            ptr_d       = ptr_q;
            lock_d      = lock_q;
            lock_unit_d = lock_unit_q;
            if (way_hs[w]) begin
                lock_d = 1'b0;
                ptr_d  = (gnt[w] == UnitW'(NumUnits - 1)) ? '0 : gnt[w] + 1'b1;
            end else if (way_req_valid_o[w]) begin
                lock_d      = 1'b1;
                lock_unit_d = gnt[w];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ptr_q       <= '0;
                lock_q      <= 1'b0;
                lock_unit_q <= '0;
            end else begin
                ptr_q       <= ptr_d;
                lock_q      <= lock_d;
                lock_unit_q <= lock_unit_d;
            end
        end
    end

    always_comb begin
        push_leg = '0;
        for (int unsigned u = 0; u < NumUnits; u++) begin
            for (int unsigned w = 0; w < NumWays; w++) begin
                if (way_hs[w] && gnt[w] == UnitW'(u)) begin
                    push_leg[u] = 1'b1;
                end
            end
        end
    end

    assign unit_req_ready_o = rst_i ? '0 : (push_leg | sel_illegal);

    assign err_d     = |sel_illegal;
    assign err_sel_o = err_q & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    for (genvar u = 0; u < NumUnits; u++) begin : g_unit
        if (ReadMask[u]) begin : g_fifo
            axi_llc_order_fifo #(
                .Depth (OrderDepth),
                .Width (NumWays)
            ) i_order_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .push_i  (push_leg[u]),
                .data_i  (unit_sel_i[u]),
                .pop_i   (rsp_pop[u]),
                .data_o  (fifo_head[u]),
                .full_o  (fifo_full[u]),
                .empty_o (fifo_empty[u])
            );
        end else begin : g_nofifo
            assign fifo_head[u]  = '0;
            assign fifo_full[u]  = 1'b0;
            assign fifo_empty[u] = 1'b1;
        end
    end

    always_comb begin
        rsp_match = '0;
        for (int unsigned u = 0; u < NumUnits; u++) begin
            for (int unsigned w = 0; w < NumWays; w++) begin
                rsp_match[u][w] = ReadMask[u] & ~fifo_empty[u] & fifo_head[u][w] &
                                  way_rsp_valid_i[w] & (way_rsp_unit_i[w] == UnitW'(u));
            end
        end
    end

    always_comb begin
        unit_rsp_o       = '0;
        unit_rsp_valid_o = '0;
        way_rsp_ready_o  = '0;
        for (int unsigned u = 0; u < NumUnits; u++) begin
            for (int unsigned w = 0; w < NumWays; w++) begin
                if (rsp_match[u][w]) begin
                    unit_rsp_o[u]       = way_rsp_i[w];
                    unit_rsp_valid_o[u] = 1'b1;
                    way_rsp_ready_o[w]  = unit_rsp_ready_i[u];
                end
            end
        end
        if (rst_i) begin
            unit_rsp_valid_o = '0;
            way_rsp_ready_o  = '0;
        end
    end

    assign rsp_pop = unit_rsp_valid_o & unit_rsp_ready_i;
    assign busy_o  = ~rst_i & ~(&fifo_empty);

    // A valid response must name a read unit whose ordering FIFO holds an entry.
    always_comb begin
        rsp_proto_err = '0;
        for (int unsigned w = 0; w < NumWays; w++) begin
            rsp_proto_err[w] = way_rsp_valid_i[w];
            for (int unsigned u = 0; u < NumUnits; u++) begin
                if (way_rsp_unit_i[w] == UnitW'(u) && ReadMask[u] && !fifo_empty[u]) begin
                    rsp_proto_err[w] = 1'b0;
                end
            end
        end
    end

    a_rsp_protocol: assert property (@(posedge clk_i) disable iff (rst_i) rsp_proto_err == '0);

endmodule

// File: tb/tb_axi_llc_way_router.sv
// Directed self-checking bench for axi_llc_way_router with default parameters.
module tb_axi_llc_way_router;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [3:0]      unit_req_i;
    logic [3:0][3:0] unit_sel_i;
    logic [3:0]      unit_req_valid_i, unit_req_ready_o;
    logic [3:0]      way_req_o;
    logic [3:0][1:0] way_req_unit_o;
    logic [3:0]      way_req_valid_o, way_req_ready_i;
    logic [3:0]      way_rsp_i;
    logic [3:0][1:0] way_rsp_unit_i;
    logic [3:0]      way_rsp_valid_i, way_rsp_ready_o;
    logic [3:0]      unit_rsp_o, unit_rsp_valid_o, unit_rsp_ready_i;
    logic            busy_o, err_sel_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    axi_llc_way_router #(
        .NumUnits   (4),
        .NumWays    (4),
        .ReadMask   (4'b1001),
        .OrderDepth (5),
        .req_t      (logic),
        .rsp_t      (logic)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .unit_req_i       (unit_req_i),
        .unit_sel_i       (unit_sel_i),
        .unit_req_valid_i (unit_req_valid_i),
        .unit_req_ready_o (unit_req_ready_o),
        .way_req_o        (way_req_o),
        .way_req_unit_o   (way_req_unit_o),
        .way_req_valid_o  (way_req_valid_o),
        .way_req_ready_i  (way_req_ready_i),
        .way_rsp_i        (way_rsp_i),
        .way_rsp_unit_i   (way_rsp_unit_i),
        .way_rsp_valid_i  (way_rsp_valid_i),
        .way_rsp_ready_o  (way_rsp_ready_o),
        .unit_rsp_o       (unit_rsp_o),
        .unit_rsp_valid_o (unit_rsp_valid_o),
        .unit_rsp_ready_i (unit_rsp_ready_i),
        .busy_o           (busy_o),
        .err_sel_o        (err_sel_o)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        unit_req_i       = '0;
        unit_sel_i       = '0;
        unit_req_valid_i = '0;
        way_req_ready_i  = 4'hF;
        way_rsp_i        = '0;
        way_rsp_unit_i   = '0;
        way_rsp_valid_i  = '0;
        unit_rsp_ready_i = 4'hF;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        unit_req_valid_i   = 4'b0001;
        unit_sel_i[0]      = 4'b0010;
        way_rsp_valid_i    = 4'b0010;
        way_rsp_unit_i[1]  = 2'd0;
        settle();
        checks++; if (unit_req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", unit_req_ready_o); end
        checks++; if (way_req_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_way_valid: got %b expected 0000", way_req_valid_o); end
        checks++; if (way_rsp_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_rsp_ready: got %b expected 0000", way_rsp_ready_o); end
        checks++; if (unit_rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", unit_rsp_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        cyc();
        checks++; if (err_sel_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_sel_o); end
        clear_inputs();
        cyc();
        rst_i = 1'b0;
        settle();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_single_read();
        cyc();
        unit_req_valid_i = 4'b0001;
        unit_sel_i[0]    = 4'b0010;
        unit_req_i[0]    = 1'b1;
        settle();
        checks++; if (way_req_valid_o !== 4'b0010) begin errors++; $display("FAIL single_way_valid: got %b expected 0010", way_req_valid_o); end
        checks++; if (way_req_o[1] !== 1'b1) begin errors++; $display("FAIL single_payload: got %b expected 1", way_req_o[1]); end
        checks++; if (way_req_unit_o[1] !== 2'd0) begin errors++; $display("FAIL single_tag: got %0d expected 0", way_req_unit_o[1]); end
        checks++; if (unit_req_ready_o !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", unit_req_ready_o); end
        cyc();
        unit_req_valid_i = '0;
        settle();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_set: got %b expected 1", busy_o); end
        checks++; if (unit_rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL single_no_early_rsp: got %b expected 0000", unit_rsp_valid_o); end
        cyc();
        cyc();
        way_rsp_valid_i   = 4'b0010;
        way_rsp_i[1]      = 1'b1;
        way_rsp_unit_i[1] = 2'd0;
        settle();
        checks++; if (unit_rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0001", unit_rsp_valid_o); end
        checks++; if (unit_rsp_o !== 4'b0001) begin errors++; $display("FAIL single_rsp_data: got %b expected 0001", unit_rsp_o); end
        checks++; if (way_rsp_ready_o !== 4'b0010) begin errors++; $display("FAIL single_way_rsp_ready: got %b expected 0010", way_rsp_ready_o); end
        cyc();
        clear_inputs();
        settle();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_clear: got %b expected 0", busy_o); end
    endtask

    task automatic test_lock_rr();
        cyc();
        way_req_ready_i  = 4'b1011;
        unit_req_valid_i = 4'b0010;
        unit_sel_i[1]    = 4'b0100;
        unit_req_i[1]    = 1'b1;
        settle();
        checks++; if (way_req_valid_o !== 4'b0100) begin errors++; $display("FAIL lock_valid: got %b expected 0100", way_req_valid_o); end
        checks++; if (way_req_unit_o[2] !== 2'd1) begin errors++; $display("FAIL lock_first_gnt: got %0d expected 1", way_req_unit_o[2]); end
        cyc();
        unit_req_valid_i = 4'b0011;
        unit_sel_i[0]    = 4'b0100;
        settle();
        checks++; if (way_req_unit_o[2] !== 2'd1) begin errors++; $display("FAIL lock_held_gnt: got %0d expected 1", way_req_unit_o[2]); end
        checks++; if (unit_req_ready_o !== 4'b0000) begin errors++; $display("FAIL lock_held_ready: got %b expected 0000", unit_req_ready_o); end
        checks++; if (way_req_o[2] !== 1'b1) begin errors++; $display("FAIL lock_held_payload: got %b expected 1", way_req_o[2]); end
        cyc();
        way_req_ready_i = 4'hF;
        settle();
        checks++; if (unit_req_ready_o !== 4'b0010) begin errors++; $display("FAIL lock_release_ready: got %b expected 0010", unit_req_ready_o); end
        cyc();
        unit_req_valid_i = 4'b0001;
        settle();
        checks++; if (way_req_unit_o[2] !== 2'd0) begin errors++; $display("FAIL rr_next_gnt: got %0d expected 0", way_req_unit_o[2]); end
        checks++; if (unit_req_ready_o !== 4'b0001) begin errors++; $display("FAIL rr_next_ready: got %b expected 0001", unit_req_ready_o); end
        cyc();
        unit_req_valid_i = 4'b1001;
        unit_sel_i[3]    = 4'b0100;
        settle();
        checks++; if (way_req_unit_o[2] !== 2'd3) begin errors++; $display("FAIL rr_advance_gnt: got %0d expected 3", way_req_unit_o[2]); end
        checks++; if (unit_req_ready_o !== 4'b1000) begin errors++; $display("FAIL rr_advance_ready: got %b expected 1000", unit_req_ready_o); end
        cyc();
        unit_req_valid_i  = '0;
        way_rsp_valid_i   = 4'b0100;
        way_rsp_i[2]      = 1'b1;
        way_rsp_unit_i[2] = 2'd3;
        settle();
        checks++; if (unit_rsp_valid_o !== 4'b1000) begin errors++; $display("FAIL tag3_rsp_valid: got %b expected 1000", unit_rsp_valid_o); end
        checks++; if (unit_rsp_o !== 4'b1000) begin errors++; $display("FAIL tag3_rsp_data: got %b expected 1000", unit_rsp_o); end
        checks++; if (way_rsp_ready_o !== 4'b0100) begin errors++; $display("FAIL tag3_way_ready: got %b expected 0100", way_rsp_ready_o); end
        cyc();
        way_rsp_i[2]      = 1'b0;
        way_rsp_unit_i[2] = 2'd0;
        settle();
        checks++; if (unit_rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL tag0_rsp_valid: got %b expected 0001", unit_rsp_valid_o); end
        checks++; if (way_rsp_ready_o !== 4'b0100) begin errors++; $display("FAIL tag0_way_ready: got %b expected 0100", way_rsp_ready_o); end
        cyc();
        clear_inputs();
        settle();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL lock_busy_clear: got %b expected 0", busy_o); end
    endtask

    task automatic test_order();
        cyc();
        unit_req_valid_i = 4'b1000;
        unit_sel_i[3]    = 4'b1000;
        settle();
        checks++; if (way_req_valid_o !== 4'b1000) begin errors++; $display("FAIL order_req1_valid: got %b expected 1000", way_req_valid_o); end
        checks++; if (unit_req_ready_o !== 4'b1000) begin errors++; $display("FAIL order_req1_ready: got %b expected 1000", unit_req_ready_o); end
        cyc();
        unit_sel_i[3] = 4'b0001;
        settle();
        checks++; if (way_req_valid_o !== 4'b0001) begin errors++; $display("FAIL order_req2_valid: got %b expected 0001", way_req_valid_o); end
        cyc();
        unit_req_valid_i  = '0;
        way_rsp_valid_i   = 4'b0001;
        way_rsp_i[0]      = 1'b1;
        way_rsp_unit_i[0] = 2'd3;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (unit_rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL order_hold_valid: got %b expected 0000", unit_rsp_valid_o); end
            checks++; if (way_rsp_ready_o !== 4'b0000) begin errors++; $display("FAIL order_hold_ready: got %b expected 0000", way_rsp_ready_o); end
            cyc();
        end
        way_rsp_valid_i   = 4'b1001;
        way_rsp_i[3]      = 1'b0;
        way_rsp_unit_i[3] = 2'd3;
        settle();
        checks++; if (unit_rsp_valid_o !== 4'b1000) begin errors++; $display("FAIL order_w3_valid: got %b expected 1000", unit_rsp_valid_o); end
        checks++; if (unit_rsp_o !== 4'b0000) begin errors++; $display("FAIL order_w3_data: got %b expected 0000", unit_rsp_o); end
        checks++; if (way_rsp_ready_o !== 4'b1000) begin errors++; $display("FAIL order_w3_ready: got %b expected 1000", way_rsp_ready_o); end
        cyc();
        way_rsp_valid_i = 4'b0001;
        settle();
        checks++; if (unit_rsp_o !== 4'b1000) begin errors++; $display("FAIL order_w0_data: got %b expected 1000", unit_rsp_o); end
        checks++; if (way_rsp_ready_o !== 4'b0001) begin errors++; $display("FAIL order_w0_ready: got %b expected 0001", way_rsp_ready_o); end
        cyc();
        clear_inputs();
        settle();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL order_busy_clear: got %b expected 0", busy_o); end
    endtask

    task automatic test_fifo_full();
        cyc();
        unit_req_valid_i = 4'b0001;
        unit_sel_i[0]    = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (unit_req_ready_o !== 4'b0001) begin errors++; $display("FAIL fill_ready_%0d: got %b expected 0001", i, unit_req_ready_o); end
            cyc();
        end
        settle();
        checks++; if (unit_req_ready_o !== 4'b0000) begin errors++; $display("FAIL full_stall_ready: got %b expected 0000", unit_req_ready_o); end
        checks++; if (way_req_valid_o !== 4'b0000) begin errors++; $display("FAIL full_stall_way_valid: got %b expected 0000", way_req_valid_o); end
        way_rsp_valid_i   = 4'b0001;
        way_rsp_unit_i[0] = 2'd0;
        way_rsp_i[0]      = 1'b1;
        settle();
        checks++; if (unit_rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL full_pop_valid: got %b expected 0001", unit_rsp_valid_o); end
        checks++; if (unit_req_ready_o !== 4'b0000) begin errors++; $display("FAIL full_pop_ready: got %b expected 0000", unit_req_ready_o); end
        cyc();
        way_rsp_valid_i = '0;
        settle();
        checks++; if (unit_req_ready_o !== 4'b0001) begin errors++; $display("FAIL one_slot_ready: got %b expected 0001", unit_req_ready_o); end
        cyc();
        settle();
        checks++; if (unit_req_ready_o !== 4'b0000) begin errors++; $display("FAIL refull_ready: got %b expected 0000", unit_req_ready_o); end
        unit_req_valid_i = '0;
        way_rsp_valid_i  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (unit_rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL drain_valid_%0d: got %b expected 0001", i, unit_rsp_valid_o); end
            cyc();
        end
        clear_inputs();
        settle();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL drain_busy_clear: got %b expected 0", busy_o); end
    endtask

    task automatic test_illegal();
        cyc();
        unit_req_valid_i = 4'b0100;
        unit_sel_i[2]    = 4'b0000;
        settle();
        checks++; if (unit_req_ready_o !== 4'b0100) begin errors++; $display("FAIL zero_hot_ready: got %b expected 0100", unit_req_ready_o); end
        checks++; if (way_req_valid_o !== 4'b0000) begin errors++; $display("FAIL zero_hot_way_valid: got %b expected 0000", way_req_valid_o); end
        checks++; if (err_sel_o !== 1'b0) begin errors++; $display("FAIL zero_hot_err_early: got %b expected 0", err_sel_o); end
        cyc();
        unit_req_valid_i = '0;
        settle();
        checks++; if (err_sel_o !== 1'b1) begin errors++; $display("FAIL zero_hot_err_pulse: got %b expected 1", err_sel_o); end
        cyc();
        checks++; if (err_sel_o !== 1'b0) begin errors++; $display("FAIL zero_hot_err_end: got %b expected 0", err_sel_o); end
        cyc();
        unit_req_valid_i = 4'b0011;
        unit_sel_i[0]    = 4'b0011;
        unit_sel_i[1]    = 4'b0000;
        settle();
        checks++; if (unit_req_ready_o !== 4'b0011) begin errors++; $display("FAIL dual_illegal_ready: got %b expected 0011", unit_req_ready_o); end
        checks++; if (way_req_valid_o !== 4'b0000) begin errors++; $display("FAIL dual_illegal_way_valid: got %b expected 0000", way_req_valid_o); end
        cyc();
        clear_inputs();
        settle();
        checks++; if (err_sel_o !== 1'b1) begin errors++; $display("FAIL dual_illegal_err_pulse: got %b expected 1", err_sel_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL dual_illegal_no_push: got %b expected 0", busy_o); end
        cyc();
        checks++; if (err_sel_o !== 1'b0) begin errors++; $display("FAIL dual_illegal_err_end: got %b expected 0", err_sel_o); end
    endtask

    task automatic test_reset_mid();
        cyc();
        unit_req_valid_i = 4'b0001;
        unit_sel_i[0]    = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cyc();
        end
        settle();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy_o); end
        rst_i = 1'b1;
        settle();
        checks++; if (unit_req_ready_o !== 4'b0000) begin errors++; $display("FAIL midreset_ready: got %b expected 0000", unit_req_ready_o); end
        checks++; if (way_req_valid_o !== 4'b0000) begin errors++; $display("FAIL midreset_way_valid: got %b expected 0000", way_req_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy_o); end
        cyc();
        rst_i = 1'b0;
        clear_inputs();
        settle();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL after_reset_busy: got %b expected 0", busy_o); end
        checks++; if (unit_rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL after_reset_rsp_valid: got %b expected 0000", unit_rsp_valid_o); end
        cyc();
        unit_req_valid_i = 4'b0001;
        unit_sel_i[0]    = 4'b0100;
        settle();
        checks++; if (way_req_valid_o !== 4'b0100) begin errors++; $display("FAIL after_reset_way_valid: got %b expected 0100", way_req_valid_o); end
        checks++; if (unit_req_ready_o !== 4'b0001) begin errors++; $display("FAIL after_reset_ready: got %b expected 0001", unit_req_ready_o); end
        cyc();
        unit_req_valid_i  = '0;
        way_rsp_valid_i   = 4'b0100;
        way_rsp_i[2]      = 1'b1;
        way_rsp_unit_i[2] = 2'd0;
        settle();
        checks++; if (unit_rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL after_reset_rsp: got %b expected 0001", unit_rsp_valid_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL after_reset_busy_set: got %b expected 1", busy_o); end
        cyc();
        clear_inputs();
        settle();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL after_reset_busy_clear: got %b expected 0", busy_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        test_reset();
        test_single_read();
        test_lock_rr();
        test_order();
        test_fifo_full();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end within 200000 time units");
        $fatal(1);
    end

endmodule
